// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and direct HI/LO writes.
// Latency: done WIDTH+2 cycles after the start cycle, or 2 cycles for divide-by-zero.
// Backpressure: start and hi_write/lo_write are ignored while busy; nothing is queued. Optional abort port via MULDIV_ABORT_EN.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_write,
  input  logic             lo_write,
  input  logic [WIDTH-1:0] wdata,
`ifdef MULDIV_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [1:0]         op_r;
  logic               neg_res;   // quotient/product sign flip
  logic               neg_rem;   // remainder follows dividend sign
  logic               dz;
  logic [WIDTH-1:0]   mcand;     // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] prod;      // {acc/remainder, multiplier/quotient}
  logic               abort_req;

`ifdef MULDIV_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Operand sign handling at start: magnitudes go into the datapath, signs are remembered
  logic             is_signed, a_neg, b_neg, start_dz;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign is_signed = ~op[0];
  assign a_neg     = is_signed & a[WIDTH-1];
  assign b_neg     = is_signed & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;
  assign start_dz  = op[1] && (b == '0);

  assign busy = (state != IDLE);

  // Next-state logic: zero-divisor divides skip RUN entirely
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = start_dz ? FINISH : RUN;
      RUN: begin
        if (abort_req)              state_nxt = IDLE;
        else if (cnt == CW'(1))     state_nxt = FINISH;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // One iteration: shift-add for multiply, restoring subtract for divide
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] step_nxt;
  always_comb begin
    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    div_shift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mcand};
    if (!op_r[1])          step_nxt = {mul_sum, prod[WIDTH-1:1]};
    else if (div_diff[WIDTH]) step_nxt = {prod[2*WIDTH-2:0], 1'b0};
    else                   step_nxt = {div_diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
  end

  // Final sign correction applied when writing HI/LO
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic [2*WIDTH-1:0] prod_neg;
  always_comb begin
    prod_neg = -prod;
    if (op_r[1]) begin
      res_lo = neg_res ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
      res_hi = neg_rem ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
    end else begin
      {res_hi, res_lo} = neg_res ? prod_neg : prod;
    end
  end

  // Datapath, HI/LO and completion pulses; done/hi/lo become visible together after FINISH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      op_r        <= '0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      dz          <= 1'b0;
      mcand       <= '0;
      prod        <= '0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_r    <= op;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            dz      <= start_dz;
            mcand   <= b_mag;
            prod    <= {{WIDTH{1'b0}}, a_mag};
            cnt     <= CW'(WIDTH);
          end else begin
            if (hi_write) hi <= wdata;
            if (lo_write) lo <= wdata;
          end
        end
        RUN: begin
          if (!abort_req) begin
            prod <= step_nxt;
            cnt  <= cnt - CW'(1);
          end
        end
        FINISH: begin
          if (!abort_req) begin
            done        <= 1'b1;
            div_by_zero <= dz;
            if (!dz) begin
              hi <= res_hi;
              lo <= res_lo;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit (WIDTH=32): directed vectors plus randomized ops against a plain-arithmetic model.
// Inputs driven and outputs sampled on the falling edge; the design samples on the rising edge.
// Abort scenario is compiled only when MULDIV_ABORT_EN is defined.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         hi_write = 1'b0;
  logic         lo_write = 1'b0;
  logic [W-1:0] wdata = '0;
`ifdef MULDIV_ABORT_EN
  logic         abort = 1'b0;
`endif
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_write(hi_write), .lo_write(lo_write), .wdata(wdata),
`ifdef MULDIV_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model: HI/LO after an operation, from plain integer arithmetic
  task automatic ref_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        inout logic [W-1:0] h, inout logic [W-1:0] l, output logic z);
    longint       sp;
    logic [63:0]  pv;
    int           sx, sy;
    z = 1'b0;
    case (o)
      2'b00: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        pv = sp;
        h = pv[63:32]; l = pv[31:0];
      end
      2'b01: begin
        pv = {32'b0, x} * {32'b0, y};
        h = pv[63:32]; l = pv[31:0];
      end
      2'b10: begin
        if (y == 0) z = 1'b1;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          l = 32'h8000_0000; h = 32'h0;
        end else begin
          sx = $signed(x); sy = $signed(y);
          l = sx / sy; h = sx % sy;
        end
      end
      default: begin
        if (y == 0) z = 1'b1;
        else begin l = x / y; h = x % y; end
      end
    endcase
  endtask

  // Issue one operation (caller is just past a falling edge) and wait for done, bounded
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] rh, output logic [W-1:0] rl, output logic rdz,
                       output int lat, output int bc);
    lat = -1; bc = 0; rh = '0; rl = '0; rdz = 1'b0;
    op = o; a = x; b = y; start = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      start = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
      if (busy) bc++;
      if (done) begin
        lat = c; rh = hi; rl = lo; rdz = div_by_zero;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b want=0", div_by_zero); end
    total++; if (hi !== '0) begin bad++; $display("FAIL reset_hi got=%h want=0", hi); end
    total++; if (lo !== '0) begin bad++; $display("FAIL reset_lo got=%h want=0", lo); end
    reset = 1'b0;
  endtask

  task automatic test_vectors;
    logic [W-1:0] rh, rl; logic z; int lat, bc;
    // First op right after reset release also shows immediate acceptance
    do_op(2'b00, 32'hFFFF_FFFF, 32'h2, rh, rl, z, lat, bc);
    total++; if (lat !== 34) begin bad++; $display("FAIL mult_latency got=%0d want=34", lat); end
    total++; if (bc !== 33) begin bad++; $display("FAIL mult_busy_cycles got=%0d want=33", bc); end
    total++; if (rh !== 32'hFFFF_FFFF || rl !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mult_result got=%h_%h want=ffffffff_fffffffe", rh, rl); end
    do_op(2'b01, 32'hFFFF_FFFF, 32'h2, rh, rl, z, lat, bc);
    total++; if (rh !== 32'h1 || rl !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_result got=%h_%h want=00000001_fffffffe", rh, rl); end
    do_op(2'b10, 32'hFFFF_FFF9, 32'h2, rh, rl, z, lat, bc);
    total++; if (rh !== 32'hFFFF_FFFF || rl !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_neg7_by_2 got=%h_%h want=ffffffff_fffffffd", rh, rl); end
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, rh, rl, z, lat, bc);
    total++; if (rh !== 32'h0 || rl !== 32'h8000_0000 || z !== 1'b0) begin bad++; $display("FAIL div_overflow got=%h_%h dbz=%b want=00000000_80000000 dbz=0", rh, rl, z); end
    m_hi = rh; m_lo = rl;
  endtask

  task automatic test_direct_write;
    hi_write = 1'b1; lo_write = 1'b1; wdata = 32'h5A5A_0001;
    @(negedge clk); hi_write = 1'b0; lo_write = 1'b0;
    total++; if (hi !== 32'h5A5A_0001 || lo !== 32'h5A5A_0001) begin bad++; $display("FAIL write_both got=%h_%h want=5a5a0001_5a5a0001", hi, lo); end
    hi_write = 1'b1; wdata = 32'h11;
    @(negedge clk); hi_write = 1'b0; lo_write = 1'b1; wdata = 32'h22;
    @(negedge clk); lo_write = 1'b0;
    total++; if (hi !== 32'h11 || lo !== 32'h22) begin bad++; $display("FAIL write_separate got=%h_%h want=00000011_00000022", hi, lo); end
    m_hi = 32'h11; m_lo = 32'h22;
  endtask

  task automatic test_div_by_zero;
    logic [W-1:0] rh, rl; logic z; int lat, bc;
    do_op(2'b11, 32'h5, 32'h0, rh, rl, z, lat, bc);
    total++; if (lat !== 2) begin bad++; $display("FAIL dbz_latency got=%0d want=2", lat); end
    total++; if (z !== 1'b1) begin bad++; $display("FAIL dbz_flag got=%b want=1", z); end
    total++; if (rh !== 32'h11 || rl !== 32'h22) begin bad++; $display("FAIL dbz_hold got=%h_%h want=00000011_00000022", rh, rl); end
    // Start wins over a simultaneous direct write: the write must be dropped
    hi_write = 1'b1; lo_write = 1'b1; wdata = 32'hAA;
    do_op(2'b10, 32'h9, 32'h0, rh, rl, z, lat, bc);
    total++; if (rh !== 32'h11 || rl !== 32'h22) begin bad++; $display("FAIL start_priority got=%h_%h want=00000011_00000022", rh, rl); end
    @(negedge clk);
    total++; if (div_by_zero !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL pulse_width done=%b dbz=%b want=0", done, div_by_zero); end
  endtask

  task automatic test_ignored;
    logic [W-1:0] eh, el; logic z; int dcnt, lat;
    logic [W-1:0] rh, rl;
    eh = m_hi; el = m_lo;
    ref_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, eh, el, z);
    dcnt = 0; lat = -1; rh = '0; rl = '0;
    op = 2'b01; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start = 1'b0; hi_write = 1'b0;
      if (done) begin dcnt++; if (lat < 0) begin lat = c; rh = hi; rl = lo; end end
      if (c == 10) begin
        start = 1'b1; op = 2'b00; a = 32'h7; b = 32'h3; hi_write = 1'b1; wdata = 32'hAA;
      end
    end
    total++; if (dcnt !== 1) begin bad++; $display("FAIL ignored_done_count got=%0d want=1", dcnt); end
    total++; if (lat !== 34) begin bad++; $display("FAIL ignored_latency got=%0d want=34", lat); end
    total++; if (rh !== eh || rl !== el) begin bad++; $display("FAIL ignored_result got=%h_%h want=%h_%h", rh, rl, eh, el); end
    total++; if (hi !== eh) begin bad++; $display("FAIL ignored_hi_write got=%h want=%h", hi, eh); end
    m_hi = eh; m_lo = el;
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] rh, rl, eh, el; logic z; int lat, bc;
    eh = m_hi; el = m_lo;
    ref_op(2'b11, 32'd1000, 32'd7, eh, el, z);
    do_op(2'b11, 32'd1000, 32'd7, rh, rl, z, lat, bc);
    // Start again in the very cycle done is seen
    ref_op(2'b00, 32'hFFFF_FF00, 32'h0000_0100, eh, el, z);
    do_op(2'b00, 32'hFFFF_FF00, 32'h0000_0100, rh, rl, z, lat, bc);
    total++; if (lat !== 34) begin bad++; $display("FAIL b2b_latency got=%0d want=34", lat); end
    total++; if (rh !== eh || rl !== el) begin bad++; $display("FAIL b2b_result got=%h_%h want=%h_%h", rh, rl, eh, el); end
    m_hi = eh; m_lo = el;
  endtask

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random;
    logic [W-1:0] rh, rl, x, y; logic z, ez; logic [1:0] o; int lat, bc;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = pick_val(); y = pick_val();
      ref_op(o, x, y, m_hi, m_lo, ez);
      do_op(o, x, y, rh, rl, z, lat, bc);
      total++; if (lat !== (ez ? 2 : 34)) begin bad++; $display("FAIL rand%0d_latency op=%0d got=%0d want=%0d", i, o, lat, ez ? 2 : 34); end
      total++; if (z !== ez) begin bad++; $display("FAIL rand%0d_dbz op=%0d got=%b want=%b", i, o, z, ez); end
      total++; if (rh !== m_hi || rl !== m_lo) begin bad++; $display("FAIL rand%0d_result op=%0d a=%h b=%h got=%h_%h want=%h_%h", i, o, x, y, rh, rl, m_hi, m_lo); end
    end
  endtask

  task automatic test_midop_reset;
    int dcnt;
    hi_write = 1'b1; lo_write = 1'b1; wdata = 32'hCAFE_0001;
    @(negedge clk); hi_write = 1'b0; lo_write = 1'b0;
    op = 2'b01; a = 32'hDEAD_BEEF; b = 32'h1234_5678; start = 1'b1;
    for (int c = 1; c <= 15; c++) begin @(negedge clk); start = 1'b0; end
    reset = 1'b1;
    #1;
    total++; if (hi !== '0 || lo !== '0) begin bad++; $display("FAIL midreset_hilo got=%h_%h want=0_0", hi, lo); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b want=0", busy); end
    @(negedge clk); reset = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 40; c++) begin @(negedge clk); if (done) dcnt++; end
    total++; if (dcnt !== 0) begin bad++; $display("FAIL midreset_done got=%0d want=0", dcnt); end
    m_hi = '0; m_lo = '0;
  endtask

`ifdef MULDIV_ABORT_EN
  task automatic test_abort;
    int dcnt;
    hi_write = 1'b1; lo_write = 1'b1; wdata = 32'h0BAD_F00D;
    @(negedge clk); hi_write = 1'b0; lo_write = 1'b0;
    op = 2'b01; a = 32'h0001_0001; b = 32'h0000_0003; start = 1'b1;
    for (int c = 1; c <= 15; c++) begin @(negedge clk); start = 1'b0; end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_idle busy=%b want=0", busy); end
    dcnt = 0;
    for (int c = 0; c < 40; c++) begin @(negedge clk); if (done) dcnt++; end
    total++; if (dcnt !== 0) begin bad++; $display("FAIL abort_done got=%0d want=0", dcnt); end
    total++; if (hi !== 32'h0BAD_F00D || lo !== 32'h0BAD_F00D) begin bad++; $display("FAIL abort_hilo got=%h_%h want=0badf00d_0badf00d", hi, lo); end
    m_hi = 32'h0BAD_F00D; m_lo = 32'h0BAD_F00D;
  endtask
`endif

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_vectors();
    test_direct_write();
    test_div_by_zero();
    test_ignored();
    test_back_to_back();
    test_random();
    test_midop_reset();
`ifdef MULDIV_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
